// File: rtl/bsg_counter_window_ctrl.sv
// Window sequencer for an external clear/up counter: clear, gate events for N cycles, capture count.
// Latency: start handshake at t -> CLEAR t+1 -> COUNT t+2..t+1+L -> CAPTURE -> sample valid at t+3+L.
// Backpressure: sample held in HOLD until sample_ready_i; new starts refused until then.
// Optional build macro BSG_COUNTER_WINDOW_AUTORESTART_EN: back-to-back windows until a stop is seen.
module bsg_counter_window_ctrl #(
    parameter int ptr_width_p    = 64,
    parameter int window_width_p = 32
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      start_v_i,
    output logic                      start_ready_o,
    input  logic [window_width_p-1:0] window_len_i,
    input  logic                      stop_i,
    input  logic                      event_i,
    output logic                      cnt_clear_o,
    output logic                      cnt_up_o,
    input  logic [ptr_width_p-1:0]    cnt_i,
    output logic                      sample_v_o,
    output logic [ptr_width_p-1:0]    sample_o,
    output logic                      overflow_o,
    input  logic                      sample_ready_i,
    output logic                      busy_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_COUNT   = 3'd2,
        S_CAPTURE = 3'd3,
        S_HOLD    = 3'd4
    } state_e;

    localparam logic [window_width_p-1:0] LenOne = window_width_p'(1);

    state_e                    state_q, state_d;
    logic [window_width_p-1:0] len_q, len_d;
    logic [window_width_p-1:0] rem_q, rem_d;
    logic [ptr_width_p-1:0]    sample_q, sample_d;
    logic                      ovf_q, ovf_d;
`ifdef BSG_COUNTER_WINDOW_AUTORESTART_EN
    logic                      stop_q, stop_d;
`endif

    // State and datapath registers; reset puts the controller back in IDLE with a cleared sample.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= S_IDLE;
            len_q    <= '0;
            rem_q    <= '0;
            sample_q <= '0;
            ovf_q    <= 1'b0;
`ifdef BSG_COUNTER_WINDOW_AUTORESTART_EN
            stop_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            rem_q    <= rem_d;
            sample_q <= sample_d;
            ovf_q    <= ovf_d;
`ifdef BSG_COUNTER_WINDOW_AUTORESTART_EN
            stop_q   <= stop_d;
`endif
        end
    end

    // Next-state and output decode; counter strobes are only ever raised in CLEAR or COUNT.
    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        rem_d         = rem_q;
        sample_d      = sample_q;
        ovf_d         = ovf_q;
`ifdef BSG_COUNTER_WINDOW_AUTORESTART_EN
        stop_d        = stop_q;
`endif
        start_ready_o = 1'b0;
        cnt_clear_o   = 1'b0;
        cnt_up_o      = 1'b0;
        sample_v_o    = 1'b0;
        overflow_o    = 1'b0;

        case (state_q)
            S_IDLE: begin
                start_ready_o = 1'b1;
                if (start_v_i) begin
                    // A zero-length window is promoted to one cycle so remaining never wraps.
                    len_d   = (window_len_i == '0) ? LenOne : window_len_i;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                cnt_clear_o = 1'b1;
                rem_d       = len_q;
                ovf_d       = 1'b0;
                state_d     = S_COUNT;
            end
            S_COUNT: begin
                cnt_up_o = event_i;
                rem_d    = rem_q - LenOne;
                if ((&cnt_i) && event_i) begin
                    ovf_d = 1'b1;
                end
`ifdef BSG_COUNTER_WINDOW_AUTORESTART_EN
                if (stop_i) begin
                    stop_d = 1'b1;
                end
`endif
                if ((rem_q == LenOne) || stop_i) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                // The last gated event has landed in the counter by now.
                sample_d = cnt_i;
                state_d  = S_HOLD;
            end
            S_HOLD: begin
                sample_v_o = 1'b1;
                overflow_o = ovf_q;
                if (sample_ready_i) begin
`ifdef BSG_COUNTER_WINDOW_AUTORESTART_EN
                    if (stop_q) begin
                        stop_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_CLEAR;
                    end
`else
                    state_d = S_IDLE;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign sample_o = sample_q;
    assign busy_o   = (state_q != S_IDLE);

endmodule

// File: tb/tb_bsg_counter_window_ctrl.sv
// Bench for bsg_counter_window_ctrl with a behavioural clear/up counter attached.
// Inputs change on the falling edge; outputs are checked 1 time unit later.
// Expected samples are queued at stimulus time and compared at the sample handshake.
module tb_bsg_counter_window_ctrl;

    logic        clk_i;
    logic        reset_n_i;
    logic        start_v_i;
    logic        start_ready_o;
    logic [31:0] window_len_i;
    logic        stop_i;
    logic        event_i;
    logic        cnt_clear_o;
    logic        cnt_up_o;
    logic [63:0] cnt_i;
    logic        sample_v_o;
    logic [63:0] sample_o;
    logic        overflow_o;
    logic        sample_ready_i;
    logic        busy_o;

    int          vectors;
    int          miscompares;
    logic [64:0] exp_q[$];   // {overflow, sample}
    bit          cnt_preset;

    bsg_counter_window_ctrl #(
        .ptr_width_p   (64),
        .window_width_p(32)
    ) dut (
        .clk_i         (clk_i),
        .reset_n_i     (reset_n_i),
        .start_v_i     (start_v_i),
        .start_ready_o (start_ready_o),
        .window_len_i  (window_len_i),
        .stop_i        (stop_i),
        .event_i       (event_i),
        .cnt_clear_o   (cnt_clear_o),
        .cnt_up_o      (cnt_up_o),
        .cnt_i         (cnt_i),
        .sample_v_o    (sample_v_o),
        .sample_o      (sample_o),
        .overflow_o    (overflow_o),
        .sample_ready_i(sample_ready_i),
        .busy_o        (busy_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Counter model; the preset option starts a window two counts below wrap.
    always @(posedge clk_i) begin
        if (cnt_clear_o) cnt_i <= cnt_preset ? 64'hFFFF_FFFF_FFFF_FFFE : 64'd0;
        else if (cnt_up_o) cnt_i <= cnt_i + 64'd1;
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic bit ev_pat(input int mode, input int k);
        case (mode)
            0:       return 1'b1;
            1:       return (k % 2) == 0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic pop_and_check();
        logic [64:0] e;
        if (exp_q.size() == 0) begin
            chk("sb_empty", 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            chk("sample", sample_o, e[63:0]);
            chk("overflow", {63'd0, overflow_o}, {63'd0, e[64]});
        end
    endtask

    // One complete window from the IDLE cycle (offset 0) through the sample handshake.
    task automatic run_window(input int len, input int mode, input int stop_cnt,
                              input int hold_wait, input bit preset);
        int          leff, ncount, nev;
        bit          done, in_count;
        logic [64:0] tot;
        leff   = (len == 0) ? 1 : len;
        ncount = (stop_cnt > 0 && stop_cnt < leff) ? stop_cnt : leff;
        nev    = 0;
        for (int k = 0; k < ncount; k++) nev += int'(ev_pat(mode, k));
        tot = (preset ? 65'h0_FFFF_FFFF_FFFF_FFFE : 65'd0) + 65'(nev);
        exp_q.push_back(tot);
        cnt_preset = preset;
        done = 1'b0;
        for (int o = 0; o < 400 && !done; o++) begin
            @(negedge clk_i);
            in_count       = (o >= 2) && (o < 2 + ncount);
            start_v_i      = (o == 0) || (hold_wait > 0 && o < 3 + ncount + hold_wait);
            window_len_i   = (o == 0) ? 32'(len) : 32'hDEAD_0003;
            event_i        = in_count ? ev_pat(mode, o - 2) : o[0];
            stop_i         = in_count ? (o == 1 + stop_cnt) : 1'b1;
            sample_ready_i = (o >= 3 + ncount + hold_wait);
            #1;
            chk("clear", {63'd0, cnt_clear_o}, {63'd0, o == 1});
            chk("up", {63'd0, cnt_up_o}, {63'd0, in_count && event_i});
            chk("excl", {63'd0, cnt_clear_o & cnt_up_o}, 64'd0);
            chk("start_rdy", {63'd0, start_ready_o}, {63'd0, o == 0});
            chk("busy", {63'd0, busy_o}, {63'd0, o != 0});
            chk("sample_v", {63'd0, sample_v_o}, {63'd0, o >= 3 + ncount});
            if (!sample_v_o) chk("ovf_invalid", {63'd0, overflow_o}, 64'd0);
            if (sample_v_o && !sample_ready_i && exp_q.size() != 0)
                chk("hold_dat", sample_o, exp_q[0][63:0]);
            if (sample_v_o && sample_ready_i) begin
                pop_and_check();
                done = 1'b1;
            end
        end
        if (!done) chk("timeout", 64'd0, 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_start_rdy"}, {63'd0, start_ready_o}, 64'd1);
        chk({tag, "_clear"}, {63'd0, cnt_clear_o}, 64'd0);
        chk({tag, "_up"}, {63'd0, cnt_up_o}, 64'd0);
        chk({tag, "_sample_v"}, {63'd0, sample_v_o}, 64'd0);
        chk({tag, "_sample"}, sample_o, 64'd0);
        chk({tag, "_ovf"}, {63'd0, overflow_o}, 64'd0);
        chk({tag, "_busy"}, {63'd0, busy_o}, 64'd0);
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        cnt_preset     = 1'b0;
        reset_n_i      = 1'b0;
        start_v_i      = 1'b0;
        window_len_i   = 32'd0;
        stop_i         = 1'b0;
        event_i        = 1'b1;
        sample_ready_i = 1'b0;
        repeat (2) @(negedge clk_i);
        #1;
        check_reset_outputs("rst");
        @(negedge clk_i);
        reset_n_i = 1'b1;

`ifdef BSG_COUNTER_WINDOW_AUTORESTART_EN
        // Three back-to-back len=4 windows; the stop in the last COUNT cycle ends the chain.
        begin
            bit in_count;
            int p;
            for (int w = 0; w < 3; w++) exp_q.push_back({1'b0, 64'd4});
            for (int o = 0; o <= 22; o++) begin
                @(negedge clk_i);
                p              = (o >= 1) ? (o - 1) % 7 : -1;
                in_count       = (o >= 1 && o <= 21 && p >= 1 && p <= 4);
                start_v_i      = (o == 0);
                window_len_i   = 32'd4;
                event_i        = 1'b1;
                stop_i         = in_count ? (o == 19) : 1'b1;
                sample_ready_i = 1'b1;
                #1;
                chk("ar_clear", {63'd0, cnt_clear_o}, {63'd0, o >= 1 && o <= 21 && p == 0});
                chk("ar_up", {63'd0, cnt_up_o}, {63'd0, in_count});
                chk("ar_sample_v", {63'd0, sample_v_o}, {63'd0, o <= 21 && p == 6});
                chk("ar_busy", {63'd0, busy_o}, {63'd0, o >= 1 && o <= 21});
                chk("ar_start_rdy", {63'd0, start_ready_o}, {63'd0, o == 0 || o == 22});
                if (sample_v_o && sample_ready_i) pop_and_check();
            end
            start_v_i = 1'b0;
            chk("ar_sb_drain", 64'(exp_q.size()), 64'd0);
        end
`else
        run_window(10, 0, 0, 0, 1'b0);    // 10
        run_window(8, 1, 0, 0, 1'b0);     // 4
        run_window(100, 0, 5, 0, 1'b0);   // 5 via stop
        run_window(0, 0, 0, 0, 1'b0);     // len 0 acts as 1 -> 1
        run_window(0, 2, 0, 0, 1'b0);     // len 0, no event -> 0
        run_window(5, 1, 0, 20, 1'b0);    // 3, held 20 cycles under backpressure
        run_window(4, 0, 0, 0, 1'b1);     // wraps: sample 2 with overflow

        // Reset in the middle of a COUNT phase, then a clean window.
        @(negedge clk_i);
        start_v_i    = 1'b1;
        window_len_i = 32'd100;
        stop_i       = 1'b0;
        event_i      = 1'b1;
        sample_ready_i = 1'b0;
        repeat (6) begin
            @(negedge clk_i);
            start_v_i = 1'b0;
        end
        #1;
        chk("pre_rst_up", {63'd0, cnt_up_o}, 64'd1);
        @(negedge clk_i);
        reset_n_i = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk_i);
        reset_n_i = 1'b1;
        run_window(6, 0, 0, 0, 1'b0);     // 6
        chk("sb_drain", 64'(exp_q.size()), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
